// File: rtl/neural_stage_collector.sv
// Output-side collector for neural_stage: realigns `first` by LATENCY, captures FRAME_LEN-sample frames
// into a two-bank ping-pong buffer and streams them out over valid/ready. Optional: NEURAL_COLLECT_RELU_EN.
module neural_stage_collector #(
    parameter int unsigned LATENCY   = 18,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned WIDTH     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             first,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overflow,
    output logic             sync_err,
    output logic [15:0]      frame_count
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_CAP  = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_SEND = 1'b1;

    logic [LATENCY-1:0] dly;
    logic               cap_start;
    logic [WIDTH-1:0]   mem [2*FRAME_LEN];
    logic [WIDTH-1:0]   store_data;

    logic [0:0]       wr_state, wr_state_nxt;
    logic [IDX_W-1:0] wr_idx, wr_idx_nxt, wr_addr;
    logic             wr_bank, wr_bank_nxt;
    logic             wr_en, set_full, bank_free;
    logic             overflow_nxt, sync_err_nxt;

    logic [0:0]       rd_state, rd_state_nxt;
    logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
    logic             rd_bank, rd_bank_nxt;
    logic             clr_full;
    logic [15:0]      frame_count_nxt;

    logic [1:0]       full, full_nxt;

    assign cap_start = dly[LATENCY-1];

`ifdef NEURAL_COLLECT_RELU_EN
    assign store_data = data_in[WIDTH-1] ? '0 : data_in;
`else
    assign store_data = data_in;
`endif

    assign out_valid = (rd_state == R_SEND);
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign out_data  = out_valid ? mem[{rd_bank, rd_idx}] : '0;

    // Read side: drain full banks in order, skipping R_IDLE when the other bank is already waiting.
    always_comb begin
        rd_state_nxt    = rd_state;
        rd_idx_nxt      = rd_idx;
        rd_bank_nxt     = rd_bank;
        clr_full        = 1'b0;
        frame_count_nxt = frame_count;
        case (rd_state)
            R_IDLE: begin
                if (full[rd_bank]) begin
                    rd_state_nxt = R_SEND;
                end
            end
            default: begin
                if (out_ready) begin
                    rd_idx_nxt = rd_idx + IDX_W'(1);
                    if (rd_idx == LAST_IDX) begin
                        clr_full        = 1'b1;
                        rd_bank_nxt     = ~rd_bank;
                        frame_count_nxt = frame_count + 16'd1;
                        if (!full[~rd_bank]) begin
                            rd_state_nxt = R_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // A bank being emptied this cycle is already free for a new frame.
    assign bank_free = !full[wr_bank] || (clr_full && (rd_bank == wr_bank));

    // Write side: capture one frame per cap_start, restart on an early cap_start.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_idx_nxt   = wr_idx;
        wr_bank_nxt  = wr_bank;
        wr_en        = 1'b0;
        wr_addr      = '0;
        set_full     = 1'b0;
        overflow_nxt = overflow;
        sync_err_nxt = sync_err;
        case (wr_state)
            W_IDLE: begin
                if (cap_start) begin
                    if (bank_free) begin
                        wr_en        = 1'b1;
                        wr_idx_nxt   = IDX_W'(1);
                        wr_state_nxt = W_CAP;
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end
            end
            default: begin
                wr_en = 1'b1;
                if (cap_start && (wr_idx != LAST_IDX)) begin
                    sync_err_nxt = 1'b1;
                    wr_idx_nxt   = IDX_W'(1);
                end else begin
                    wr_addr    = wr_idx;
                    wr_idx_nxt = wr_idx + IDX_W'(1);
                    if (wr_idx == LAST_IDX) begin
                        set_full     = 1'b1;
                        wr_bank_nxt  = ~wr_bank;
                        wr_state_nxt = W_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        full_nxt = full;
        if (clr_full) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (set_full) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly         <= '0;
            wr_state    <= W_IDLE;
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            rd_state    <= R_IDLE;
            rd_idx      <= '0;
            rd_bank     <= 1'b0;
            full        <= '0;
            overflow    <= 1'b0;
            sync_err    <= 1'b0;
            frame_count <= '0;
        end else begin
            dly         <= LATENCY'({dly, first});
            wr_state    <= wr_state_nxt;
            wr_idx      <= wr_idx_nxt;
            wr_bank     <= wr_bank_nxt;
            rd_state    <= rd_state_nxt;
            rd_idx      <= rd_idx_nxt;
            rd_bank     <= rd_bank_nxt;
            full        <= full_nxt;
            overflow    <= overflow_nxt;
            sync_err    <= sync_err_nxt;
            frame_count <= frame_count_nxt;
        end
    end

    // Frame storage; contents need no reset since the full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= store_data;
        end
    end

endmodule

// File: tb/tb_neural_stage_collector.sv
// Self-checking bench for neural_stage_collector: directed sequences, a vector table and a randomized
// run, all checked against a frame-level queue model. Honours NEURAL_COLLECT_RELU_EN like the design.
module tb_neural_stage_collector;

    localparam int unsigned LATENCY   = 18;
    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned WIDTH     = 32;

    logic        clk = 1'b0;
    logic        reset, first, out_ready;
    logic [31:0] data_in;
    logic [31:0] out_data;
    logic        out_valid, out_last, overflow, sync_err;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    neural_stage_collector #(
        .LATENCY  (LATENCY),
        .FRAME_LEN(FRAME_LEN),
        .WIDTH    (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .first      (first),
        .data_in    (data_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .sync_err   (sync_err),
        .frame_count(frame_count)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[16];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;
    int          t0 = 0;

    // Frame-level reference: held frame count, the frame being captured, and a queue of deliverable samples.
    logic [31:0] q[$];
    int          m_rdpos, m_slots, m_ccnt;
    logic [15:0] m_fc;
    bit          m_ovf, m_sync, m_capt;
    logic [31:0] m_frame[16];
    bit          fring[64];

    int          ev_xfers, ev_first_valid, ev_first_xfer, ev_last_xfer;
    logic [31:0] ev_data[64];

    function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef NEURAL_COLLECT_RELU_EN
        return d[31] ? 32'd0 : d;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdpos = 0; m_slots = 0; m_ccnt = 0; m_fc = '0;
        m_ovf = 1'b0; m_sync = 1'b0; m_capt = 1'b0;
        for (int i = 0; i < 64; i++) fring[i] = 1'b0;
    endtask

    task automatic clr_ev();
        ev_xfers = 0; ev_first_valid = -1; ev_first_xfer = -1; ev_last_xfer = -1;
        t0 = cyc;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rs, input bit f, input logic [31:0] d, input bit rdy);
        bit cap;
        reset = rs; first = f; data_in = d; out_ready = rdy;
        #1;
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("sync_err", 32'(sync_err), 32'(m_sync));
        if (out_valid) begin
            if (ev_first_valid < 0) ev_first_valid = cyc;
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_valid: out_valid=1 with nothing buffered, required 0 (cycle %0d)", cyc);
            end else begin
                chk("out_data", out_data, q[0]);
                chk("out_last", 32'(out_last), 32'(m_rdpos == 15));
            end
            if (rdy) begin
                if (ev_xfers < 64) ev_data[ev_xfers] = out_data;
                if (ev_first_xfer < 0) ev_first_xfer = cyc;
                ev_last_xfer = cyc;
                ev_xfers++;
                if (q.size() != 0) begin
                    void'(q.pop_front());
                    m_rdpos++;
                    if (m_rdpos == 16) begin
                        m_rdpos = 0; m_fc++; m_slots--;
                    end
                end
            end
        end
        cap = fring[(cyc + 64 - LATENCY) % 64];
        fring[cyc % 64] = f;
        if (rs) begin
            model_reset();
        end else begin
            if (cap) begin
                if (m_capt) begin
                    if (m_ccnt < 15) begin
                        m_sync = 1'b1; m_ccnt = 0;
                    end
                end else if (m_slots < 2) begin
                    m_slots++; m_capt = 1'b1; m_ccnt = 0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_capt) begin
                m_frame[m_ccnt] = relu(d);
                m_ccnt++;
                if (m_ccnt == 16) begin
                    for (int i = 0; i < 16; i++) q.push_back(m_frame[i]);
                    m_capt = 1'b0;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, $urandom, 1'b0);
        step(1'b1, 1'b0, $urandom, 1'b0);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        clr_ev();
    endtask

    task automatic tv(input int i, input logic [31:0] d, input logic [31:0] e_relu);
        vt[i].din = d;
`ifdef NEURAL_COLLECT_RELU_EN
        vt[i].exp = e_relu;
`else
        vt[i].exp = d;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g, next_f;
        logic [31:0] d28;

        tv(0,  32'hBF800000, 32'h00000000);
        tv(1,  32'h40000000, 32'h40000000);
        tv(2,  32'h80000000, 32'h00000000);
        tv(3,  32'h00000000, 32'h00000000);
        tv(4,  32'h3F800000, 32'h3F800000);
        tv(5,  32'hC2C80000, 32'h00000000);
        tv(6,  32'h7F7FFFFF, 32'h7F7FFFFF);
        tv(7,  32'hFFFFFFFF, 32'h00000000);
        tv(8,  32'h00000001, 32'h00000001);
        tv(9,  32'h80000001, 32'h00000000);
        tv(10, 32'h42280000, 32'h42280000);
        tv(11, 32'hBF000000, 32'h00000000);
        tv(12, 32'h3EAAAAAB, 32'h3EAAAAAB);
        tv(13, 32'hDEADBEEF, 32'h00000000);
        tv(14, 32'h12345678, 32'h12345678);
        tv(15, 32'h7FFFFFFF, 32'h7FFFFFFF);

        reset = 1'b1; first = 1'b0; data_in = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        clr_ev();

        // Single frame with ascending payload
        do_reset();
        for (int i = 0; i < 70; i++)
            step(1'b0, i == 0, (i >= 18 && i < 34) ? 32'h3F800000 + 32'(i - 18) : $urandom, 1'b1);
        chk("single_first_valid_cycle", 32'(ev_first_valid - t0), 32'd35);
        chk("single_xfers", 32'(ev_xfers), 32'd16);
        chk("single_sample0", ev_data[0], 32'h3F800000);
        chk("single_sample15", ev_data[15], 32'h3F80000F);
        chk("single_frame_count", 32'(frame_count), 32'd1);

        // Four back-to-back frames
        do_reset();
        for (int i = 0; i < 130; i++)
            step(1'b0, (i % 16 == 0) && (i < 64), $urandom, 1'b1);
        chk("b2b_xfers", 32'(ev_xfers), 32'd64);
        chk("b2b_contiguous_span", 32'(ev_last_xfer - ev_first_xfer), 32'd63);
        chk("b2b_overflow", 32'(overflow), 32'd0);
        chk("b2b_sync_err", 32'(sync_err), 32'd0);
        chk("b2b_frame_count", 32'(frame_count), 32'd4);

        // Backpressure: third frame must be dropped
        do_reset();
        for (int i = 0; i < 150; i++)
            step(1'b0, (i % 16 == 0) && (i < 48), $urandom, i >= 80);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_xfers", 32'(ev_xfers), 32'd32);
        chk("bp_frame_count", 32'(frame_count), 32'd2);

        // Early restart 10 cycles into a frame
        do_reset();
        d28 = '0;
        for (int i = 0; i < 90; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i == 28) d28 = d;
            step(1'b0, (i == 0) || (i == 10), d, 1'b1);
        end
        chk("sync_flag", 32'(sync_err), 32'd1);
        chk("sync_xfers", 32'(ev_xfers), 32'd16);
        chk("sync_sample0", ev_data[0], relu(d28));
        chk("sync_frame_count", 32'(frame_count), 32'd1);

        // Reset while sample 5 is being presented
        do_reset();
        n = 0;
        while (ev_xfers < 5 && n < 80) begin
            step(1'b0, n == 0, $urandom, 1'b1);
            n++;
        end
        chk("rmid_reach_idx5", 32'(ev_xfers), 32'd5);
        step(1'b1, 1'b0, $urandom, 1'b1);
        #1;
        chk("rmid_out_valid", 32'(out_valid), 32'd0);
        chk("rmid_frame_count", 32'(frame_count), 32'd0);
        clr_ev();
        for (int i = 0; i < 70; i++)
            step(1'b0, i == 0, (i >= 18 && i < 34) ? 32'h40000000 + 32'(i - 18) : $urandom, 1'b1);
        chk("rmid_xfers", 32'(ev_xfers), 32'd16);
        chk("rmid_sample0", ev_data[0], 32'h40000000);
        chk("rmid_first_valid_cycle", 32'(ev_first_valid - t0), 32'd35);

        // Vector table through one frame
        do_reset();
        for (int i = 0; i < 70; i++)
            step(1'b0, i == 0, (i >= 18 && i < 34) ? vt[i - 18].din : $urandom, 1'b1);
        chk("vec_xfers", 32'(ev_xfers), 32'd16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("vec%0d", k), ev_data[k], vt[k].exp);

        // Randomized traffic with random backpressure
        do_reset();
        next_f = 3;
        for (int i = 0; i < 1500; i++) begin
            bit f, rdy;
            f = (i == next_f) && (i < 1400);
            if (i == next_f) begin
                g = int'($urandom_range(2, 30));
                if (g == 15 || ($urandom % 2) == 0) g = 16;
                next_f = i + g;
            end
            rdy = (((i / 200) % 3) == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(1'b0, f, $urandom, rdy);
        end
        for (int i = 0; i < 150; i++)
            step(1'b0, 1'b0, $urandom, 1'b1);
        chk("random_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
